alu_opnd_sel_pipe: RTL

//  Parametrised, registered operand-B selector for the EX stage of the 5-stage MIPS pipeline.

---
 rtl/alu_opnd_pkg.sv | 11 +
 rtl/opnd_skid_buf.sv | 64 ++++++
 rtl/alu_opnd_sel_pipe.sv | 79 +++++++
 3 files changed

// File: rtl/alu_opnd_pkg.sv
// alu_opnd_pkg: shared operand-B extension modes and default widths
//   EXT_* : 2-bit ext_mode encodings seen by the EX-stage operand selector
//   DEF_DATA_W / DEF_IMM_W : datapath defaults shared with decoder and forwarding unit
package alu_opnd_pkg;
    localparam logic [1:0] EXT_NONE = 2'b00;
    localparam logic [1:0] EXT_SEXT = 2'b01;
    localparam logic [1:0] EXT_ZEXT = 2'b10;
    localparam logic [1:0] EXT_LUI  = 2'b11;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_IMM_W  = 16;
endpackage

// File: rtl/opnd_skid_buf.sv
// opnd_skid_buf: generic 2-entry valid/ready skid register (main + skid, FIFO order)
//   clk, rst_n            : clock, async active-low reset
//   flush                 : drop both entries and the same-cycle input
//   in_valid/in_ready     : upstream handshake; in_ready is a flop output
//   in_data [W]           : incoming word
//   out_valid/out_ready   : downstream handshake
//   out_data [W]          : main entry (oldest word)
module opnd_skid_buf #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic         main_v_q, main_v_d, skid_v_q, skid_v_d;
    logic [W-1:0] main_q, main_d, skid_q, skid_d;
    logic         acc, xfer;

    always_comb begin
        xfer     = main_v_q & out_ready;
        acc      = in_valid & ~skid_v_q & ~flush;
        main_v_d = main_v_q;
        main_d   = main_q;
        skid_v_d = skid_v_q;
        skid_d   = skid_q;
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (!main_v_q || xfer) begin
            // main frees up: refill from skid first (older), else from input;
            // skid is empty afterwards because acc cannot coincide with skid_v
            main_v_d = skid_v_q | acc;
            main_d   = skid_v_q ? skid_q : (acc ? in_data : main_q);
            skid_v_d = 1'b0;
        end else if (acc) begin
            skid_v_d = 1'b1;
            skid_d   = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
        end else begin
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
        end
    end

    assign in_ready  = ~skid_v_q;
    assign out_valid = main_v_q;
    assign out_data  = main_q;
endmodule

// File: rtl/alu_opnd_sel_pipe.sv
// alu_opnd_sel_pipe: registered operand-B selector for the EX stage
//   clk, rst_n            : clock, async active-low reset
//   flush                 : squash held and incoming operands
//   in_valid/in_ready     : upstream request handshake
//   src_sel [SEL_W]       : source index when ext_mode is EXT_NONE
//   ext_mode [2]          : NONE / SEXT / ZEXT / LUI
//   src_data [NUM_SRC*DATA_W] : flattened sources, src k at [k*DATA_W +: DATA_W]
//   imm [IMM_W]           : raw instruction immediate
//   out_valid/out_ready   : ALU handshake
//   out_data [DATA_W]     : selected operand B
//   sel_err               : sticky, an out-of-range src_sel was accepted
module alu_opnd_sel_pipe
    import alu_opnd_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 2,
    parameter int IMM_W   = DEF_IMM_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SEL_W-1:0]          src_sel,
    input  logic [1:0]                ext_mode,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [IMM_W-1:0]          imm,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic                      sel_err
);
    if ((2 ** SEL_W) < NUM_SRC || IMM_W > DATA_W || NUM_SRC < 2) begin : g_bad_params
        $error("alu_opnd_sel_pipe: illegal SEL_W/NUM_SRC/IMM_W/DATA_W combination");
    end

    // Pad the source table to every encodable index; unused slots alias src[0]
    logic [DATA_W-1:0] src_arr [2**SEL_W];
    for (genvar k = 0; k < 2 ** SEL_W; k++) begin : g_src
        if (k < NUM_SRC) begin : g_real
            assign src_arr[k] = src_data[k*DATA_W +: DATA_W];
        end else begin : g_alias
            assign src_arr[k] = src_data[DATA_W-1:0];
        end
    end

    logic [DATA_W-1:0] opnd;
    logic              sel_bad, accept, sel_err_q, sel_err_d;

    always_comb begin
        opnd = ext_mode == EXT_NONE ? src_arr[src_sel] :
               ext_mode == EXT_SEXT ? DATA_W'($signed(imm)) :
               ext_mode == EXT_ZEXT ? DATA_W'(imm) :
                                      DATA_W'(imm) << (DATA_W - IMM_W);
        sel_bad   = {1'b0, src_sel} >= (SEL_W + 1)'(NUM_SRC);
        accept    = in_valid & in_ready & ~flush;
        sel_err_d = sel_err_q | (accept & (ext_mode == EXT_NONE) & sel_bad);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sel_err_q <= 1'b0;
        else        sel_err_q <= sel_err_d;
    end

    assign sel_err = sel_err_q;

    opnd_skid_buf #(.W(DATA_W)) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (opnd),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );
endmodule
